// File: rtl/ysyx_00000000_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 values, FSM states,
// bus response codes and byte-strobe base masks.
package ysyx_00000000_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  localparam logic [STRB_W-1:0] STRB_BYTE = 4'b0001;
  localparam logic [STRB_W-1:0] STRB_HALF = 4'b0011;
  localparam logic [STRB_W-1:0] STRB_WORD = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_RESP
  } lsu_state_e;

  // Request fields that must outlive the accept cycle
  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
  } lsu_req_t;

  function automatic logic funct3_illegal(input logic wen, input logic [2:0] f3);
    if (wen) return f3[2] | (f3[1:0] == 2'b11);
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/ysyx_00000000_lsu_align.sv
// Byte-lane alignment: store data/strobe shifting, load extraction with
// sign/zero extension, and misalignment detection.
module ysyx_00000000_lsu_align
  import ysyx_00000000_lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata_c,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [XLEN-1:0]   rdata_ext_c,
  output logic              misalign_c
);

  logic [4:0]        shamt;
  logic [XLEN-1:0]   rshift;
  logic [STRB_W-1:0] strb_base;

  always_comb begin
    shamt     = {addr_lo, 3'b000};
    wdata_c   = wdata << shamt;
    rshift    = rdata >> shamt;
    strb_base = '0;
    case (funct3[1:0])
      2'b00:   strb_base = STRB_BYTE;
      2'b01:   strb_base = STRB_HALF;
      2'b10:   strb_base = STRB_WORD;
      default: strb_base = '0;
    endcase
    wstrb_c    = strb_base << addr_lo;
    misalign_c = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
                 ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
    rdata_ext_c = '0;
    case (funct3)
      F3_LB:   rdata_ext_c = {{24{rshift[7]}}, rshift[7:0]};
      F3_LH:   rdata_ext_c = {{16{rshift[15]}}, rshift[15:0]};
      F3_LW:   rdata_ext_c = rshift;
      F3_LBU:  rdata_ext_c = {24'd0, rshift[7:0]};
      F3_LHU:  rdata_ext_c = {16'd0, rshift[15:0]};
      default: rdata_ext_c = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_00000000_lsu.sv
// Load/store unit front-end: one request at a time from EXU, issued on the
// narrow AXI-style read or write channels, result returned to WBU.
module ysyx_00000000_lsu
  import ysyx_00000000_lsu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              exu_arvalid,
  input  logic              exu_arready,
  output logic [XLEN-1:0]   exu_araddr,
  output logic [2:0]        exu_arsize,
  input  logic              lsu_rvalid,
  output logic              lsu_rready,
  input  logic [XLEN-1:0]   lsu_rdata,
  input  logic [1:0]        lsu_rresp,
  output logic              exu_awvalid,
  input  logic              exu_awready,
  output logic [XLEN-1:0]   exu_awaddr,
  output logic              exu_wvalid,
  input  logic              exu_wready,
  output logic [XLEN-1:0]   exu_wdata,
  output logic [STRB_W-1:0] exu_wstrb,
  input  logic              lsu_bvalid,
  output logic              lsu_bready,
  input  logic [1:0]        lsu_bresp
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q;
  logic              accept_c;
  logic              pre_err_c;
  logic [2:0]        al_funct3;
  logic [1:0]        al_addr_lo;
  logic [XLEN-1:0]   al_wdata;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_rdata_ext;
  logic              al_misalign;

  // In IDLE the aligner looks at the incoming request; afterwards at the captured one
  assign al_funct3  = (state_q == S_IDLE) ? req_funct3     : req_q.funct3;
  assign al_addr_lo = (state_q == S_IDLE) ? req_addr[1:0]  : req_q.addr[1:0];

  ysyx_00000000_lsu_align u_align (
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .wdata       (req_wdata),
    .rdata       (lsu_rdata),
    .wdata_c     (al_wdata),
    .wstrb_c     (al_wstrb),
    .rdata_ext_c (al_rdata_ext),
    .misalign_c  (al_misalign)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    pre_err_c = funct3_illegal(req_wen, req_funct3) | al_misalign;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (pre_err_c)    state_d = S_RESP;
          else if (req_wen) state_d = S_WREQ;
          else              state_d = S_RADDR;
        end
      end
      S_RADDR: if (exu_arready)               state_d = S_RDATA;
      S_RDATA: if (lsu_rvalid)                state_d = S_RESP;
      S_WREQ:  if (exu_awready && exu_wready) state_d = S_WRESP;
      S_WRESP: if (lsu_bvalid)                state_d = S_RESP;
      S_RESP:  if (resp_ready)                state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready   <= 1'b1;
      exu_arvalid <= 1'b0;
      lsu_rready  <= 1'b0;
      exu_awvalid <= 1'b0;
      exu_wvalid  <= 1'b0;
      lsu_bready  <= 1'b0;
      resp_valid  <= 1'b0;
      req_q       <= '0;
      exu_wdata   <= '0;
      exu_wstrb   <= '0;
      resp_rdata  <= '0;
      resp_tag    <= '0;
      resp_err    <= 1'b0;
    end else begin
      req_ready   <= (state_d == S_IDLE);
      exu_arvalid <= (state_d == S_RADDR);
      lsu_rready  <= (state_d == S_RDATA);
      exu_awvalid <= (state_d == S_WREQ);
      exu_wvalid  <= (state_d == S_WREQ);
      lsu_bready  <= (state_d == S_WRESP);
      resp_valid  <= (state_d == S_RESP);
      if (accept_c) begin
        req_q.funct3 <= req_funct3;
        req_q.addr   <= req_addr;
        exu_wdata    <= al_wdata;
        exu_wstrb    <= al_wstrb;
        resp_tag     <= req_tag;
        resp_rdata   <= '0;
        resp_err     <= pre_err_c;
      end
      if ((state_q == S_RDATA) && lsu_rvalid) begin
        resp_err   <= (lsu_rresp != AXI_OKAY);
        resp_rdata <= (lsu_rresp == AXI_OKAY) ? al_rdata_ext : '0;
      end
      if ((state_q == S_WRESP) && lsu_bvalid) begin
        resp_err   <= (lsu_bresp != AXI_OKAY);
        resp_rdata <= '0;
      end
    end
  end

  assign exu_araddr = req_q.addr;
  assign exu_awaddr = req_q.addr;
  assign exu_arsize = {1'b0, req_q.funct3[1:0]};

endmodule

// File: tb/tb_ysyx_00000000_lsu.sv
// Directed plus randomized bench for the LSU with an in-bench reference model
// and an AXI-style slave driven from the same initial block.
module tb_ysyx_00000000_lsu;

  localparam int unsigned TAG_W = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wen = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;
  logic              exu_arvalid;
  logic              exu_arready = 1'b0;
  logic [31:0]       exu_araddr;
  logic [2:0]        exu_arsize;
  logic              lsu_rvalid = 1'b0;
  logic              lsu_rready;
  logic [31:0]       lsu_rdata = '0;
  logic [1:0]        lsu_rresp = '0;
  logic              exu_awvalid;
  logic              exu_awready = 1'b0;
  logic [31:0]       exu_awaddr;
  logic              exu_wvalid;
  logic              exu_wready = 1'b0;
  logic [31:0]       exu_wdata;
  logic [3:0]        exu_wstrb;
  logic              lsu_bvalid = 1'b0;
  logic              lsu_bready;
  logic [1:0]        lsu_bresp = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_00000000_lsu #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .exu_arvalid(exu_arvalid), .exu_arready(exu_arready), .exu_araddr(exu_araddr),
    .exu_arsize(exu_arsize),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .exu_awvalid(exu_awvalid), .exu_awready(exu_awready), .exu_awaddr(exu_awaddr),
    .exu_wvalid(exu_wvalid), .exu_wready(exu_wready), .exu_wdata(exu_wdata), .exu_wstrb(exu_wstrb),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: rules stated in terms of access size in bytes
  function automatic logic model_illegal(input logic wen, input logic [2:0] f3);
    if (wen) return (f3 > 3'd2);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_misalign(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = nbytes(f3);
    if (n > 4) return 1'b0;
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] s;
    logic [31:0] v;
    s = rd >> (8 * addr[1:0]);
    case (f3)
      3'd0: begin v = s & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd1: begin v = s & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd2: v = s;
      3'd4: v = s & 32'hFF;
      3'd5: v = s & 32'hFFFF;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << nbytes(f3)) - 1) << addr[1:0];
    return 4'(m & 15);
  endfunction

  // One full transaction: drive request, play bus slave, check the response
  task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [1:0] bus_resp, input logic [TAG_W-1:0] tag,
                         input logic [31:0] aw_mask, input logic [31:0] w_mask,
                         input int ar_wait, input int r_wait, input int hold);
    logic        pre;
    logic        exp_err;
    logic [31:0] exp_data;
    logic        a;
    logic        w;
    logic        done;
    int          n;
    pre = model_illegal(wen, f3) || model_misalign(f3, addr);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_tag = tag;
    @(negedge clock);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    if (pre) begin
      check("err_latency", 32'(resp_valid), 32'd1);
      check("err_no_bus", 32'({exu_arvalid, exu_awvalid, exu_wvalid}), 32'd0);
      exp_err  = 1'b1;
      exp_data = 32'd0;
    end else if (!wen) begin
      check("arvalid", 32'(exu_arvalid), 32'd1);
      check("araddr", exu_araddr, addr);
      check("arsize", 32'(exu_arsize), 32'(f3[1:0]));
      for (int i = 0; i < ar_wait; i++) begin
        @(negedge clock);
        check("ar_hold", 32'(exu_arvalid), 32'd1);
        check("ar_addr_hold", exu_araddr, addr);
      end
      exu_arready = 1'b1;
      @(negedge clock);
      exu_arready = 1'b0;
      check("arvalid_drop", 32'(exu_arvalid), 32'd0);
      repeat (r_wait) @(negedge clock);
      lsu_rvalid = 1'b1; lsu_rdata = rdata; lsu_rresp = bus_resp;
      check("rready", 32'(lsu_rready), 32'd1);
      @(negedge clock);
      lsu_rvalid = 1'b0; lsu_rdata = $urandom; lsu_rresp = 2'b00;
      exp_err  = (bus_resp != 2'b00);
      exp_data = exp_err ? 32'd0 : model_load(f3, addr, rdata);
    end else begin
      n = 0; done = 1'b0;
      while (!done && n < 40) begin
        check("aw_w_valid", 32'({exu_awvalid, exu_wvalid}), 32'd3);
        check("awaddr", exu_awaddr, addr);
        check("wdata", exu_wdata, wdata << (8 * addr[1:0]));
        check("wstrb", 32'(exu_wstrb), 32'(model_strb(f3, addr)));
        a = (n >= 24) ? 1'b1 : aw_mask[n];
        w = (n >= 24) ? 1'b1 : w_mask[n];
        exu_awready = a; exu_wready = w;
        @(negedge clock);
        exu_awready = 1'b0; exu_wready = 1'b0;
        done = a && w;
        n++;
      end
      check("aw_w_drop", 32'({exu_awvalid, exu_wvalid}), 32'd0);
      repeat (r_wait) @(negedge clock);
      lsu_bvalid = 1'b1; lsu_bresp = bus_resp;
      check("bready", 32'(lsu_bready), 32'd1);
      @(negedge clock);
      lsu_bvalid = 1'b0; lsu_bresp = 2'b00;
      exp_err  = (bus_resp != 2'b00);
      exp_data = 32'd0;
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_data);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    check("resp_rdata", resp_rdata, exp_data);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_tag", 32'(resp_tag), 32'(tag));
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("resp_valid_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_valids", 32'({exu_arvalid, lsu_rready, exu_awvalid, exu_wvalid, lsu_bready, resp_valid}), 32'd0);
    check("rst_resp", resp_rdata | 32'(resp_tag) | 32'(resp_err), 32'd0);

    // lb with top-lane byte 0x80
    run_txn(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80AA_5511, 2'b00, 5'd1, 0, 0, 0, 0, 0);
    check("lb_value", resp_rdata, 32'hFFFF_FF80);
    resp_ready = 1'b0;
    run_txn(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'hBEEF_1234, 2'b00, 5'd2, 0, 0, 1, 2, 0);
    run_txn(1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'hBEEF_1234, 2'b00, 5'd3, 0, 0, 0, 0, 1);
    // sb: awready pulses in cycle 1, wready in cycle 3, both in cycle 5
    run_txn(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'd0, 2'b00, 5'd4,
            32'h0000_0022, 32'h0000_0028, 0, 0, 0);
    run_txn(1'b1, 3'b010, 32'h8000_0006, 32'h1234_5678, 32'd0, 2'b00, 5'd5, 0, 0, 0, 0, 0);
    run_txn(1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hCAFE_F00D, 2'b10, 5'd6, 0, 0, 0, 1, 5);
    run_txn(1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'd0, 2'b00, 5'd7, 0, 0, 0, 0, 0);
    run_txn(1'b1, 3'b001, 32'h8000_0003, 32'hFFFF, 32'd0, 2'b00, 5'd8, 0, 0, 0, 0, 0);
    run_txn(1'b1, 3'b100, 32'h8000_0000, 32'hFF, 32'd0, 2'b00, 5'd9, 0, 0, 0, 0, 0);
    run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'd0, 2'b11, 5'd10,
            32'h1, 32'h1, 0, 2, 1);

    // Reset while waiting for read data abandons the load
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0020; req_tag = 5'd11;
    @(negedge clock);
    req_valid = 1'b0;
    exu_arready = 1'b1;
    @(negedge clock);
    exu_arready = 1'b0;
    check("pre_rst_rready", 32'(lsu_rready), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valids", 32'({exu_arvalid, lsu_rready, exu_awvalid, exu_wvalid, lsu_bready, resp_valid}), 32'd0);
    reset = 1'b0;
    lsu_rvalid = 1'b1; lsu_rdata = 32'h5555_5555;
    @(negedge clock);
    lsu_rvalid = 1'b0;
    check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Randomized mix of loads, stores, illegal and misaligned requests
    for (int k = 0; k < 60; k++) begin
      wen  = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      run_txn(wen, f3, addr, $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, 5'($urandom_range(0, 31)),
              $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
